// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the two master request/response channels and the shared memory
//   port of mem_arbiter.
//
//   Modports:
//     slave  - the arbiter side: takes requests and mem_rd_data, returns
//              acks/read data and drives the mem_* port and busy.
//     master - the opposite side (masters plus memory model), used by
//              whatever instantiates the arbiter.
//
//   Signals (per master mN, N = 0/1):
//     mN_req, mN_addr[AW], mN_wr, mN_byt, mN_wr_data[16]  request fields
//     mN_ack, mN_rd_data[16]                              completion
//   Memory port:
//     mem_addr[AW], mem_wr, mem_byt, mem_wr_data[16]      to mem
//     mem_rd_data[16]                                     from mem
//     busy                                                debug/monitor
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int AW = 16
);
    logic          m0_req;
    logic [AW-1:0] m0_addr;
    logic          m0_wr;
    logic          m0_byt;
    logic [15:0]   m0_wr_data;
    logic          m0_ack;
    logic [15:0]   m0_rd_data;

    logic          m1_req;
    logic [AW-1:0] m1_addr;
    logic          m1_wr;
    logic          m1_byt;
    logic [15:0]   m1_wr_data;
    logic          m1_ack;
    logic [15:0]   m1_rd_data;

    logic [AW-1:0] mem_addr;
    logic          mem_wr;
    logic          mem_byt;
    logic [15:0]   mem_wr_data;
    logic [15:0]   mem_rd_data;

    logic          busy;

    modport slave (
        input  m0_req, m0_addr, m0_wr, m0_byt, m0_wr_data,
        output m0_ack, m0_rd_data,
        input  m1_req, m1_addr, m1_wr, m1_byt, m1_wr_data,
        output m1_ack, m1_rd_data,
        output mem_addr, mem_wr, mem_byt, mem_wr_data,
        input  mem_rd_data,
        output busy
    );

    modport master (
        output m0_req, m0_addr, m0_wr, m0_byt, m0_wr_data,
        input  m0_ack, m0_rd_data,
        output m1_req, m1_addr, m1_wr, m1_byt, m1_wr_data,
        input  m1_ack, m1_rd_data,
        input  mem_addr, mem_wr, mem_byt, mem_wr_data,
        output mem_rd_data,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single 16-bit memory port between the CPU data port (m0) and a
//   secondary bus master (m1) with round-robin fairness. The winning request
//   is registered onto mem_*, held for one ACCESS cycle while the BRAM samples
//   it, and completed in DONE with a one-cycle ack to the owner.
//
//   Ports:
//     clk  - clock
//     rst  - asynchronous, active-high reset
//     bus  - mem_arbiter_if.slave: both master channels, memory port, busy
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          grant;          // start a new access at the coming edge
    logic          grant_m1;       // winner of that grant: 0 = m0, 1 = m1
    logic          owner_q;        // master owning the in-flight access
    logic          last_grant_q;   // most recent winner, for round-robin
    logic          op_wr_q;        // in-flight access is a write

    logic [AW-1:0] mem_addr_q;
    logic          mem_wr_q;
    logic          mem_byt_q;
    logic [15:0]   mem_wr_data_q;
    logic          m0_ack_q, m1_ack_q;
    logic [15:0]   m0_hold_q, m1_hold_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        grant_m1 = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    grant    = 1'b1;
                    // On a tie the master that did not win last time goes.
                    grant_m1 = bus.m1_req && (!bus.m0_req || !last_grant_q);
                    state_d  = ACCESS;
                end
            end
            ACCESS: state_d = DONE;
            DONE: begin
                // The owner's req in its ack cycle is still its old request,
                // so only the other master can be granted back-to-back.
                if (!owner_q && bus.m1_req) begin
                    grant    = 1'b1;
                    grant_m1 = 1'b1;
                end else if (owner_q && bus.m0_req) begin
                    grant    = 1'b1;
                    grant_m1 = 1'b0;
                end
                state_d = grant ? ACCESS : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q    <= '0;
            mem_wr_q      <= 1'b0;
            mem_byt_q     <= 1'b0;
            mem_wr_data_q <= '0;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;      // m0 wins the first tie
            op_wr_q       <= 1'b0;
            m0_ack_q      <= 1'b0;
            m1_ack_q      <= 1'b0;
            m0_hold_q     <= '0;
            m1_hold_q     <= '0;
        end else begin
            if (grant) begin
                mem_addr_q    <= grant_m1 ? bus.m1_addr    : bus.m0_addr;
                mem_wr_q      <= grant_m1 ? bus.m1_wr      : bus.m0_wr;
                mem_byt_q     <= grant_m1 ? bus.m1_byt     : bus.m0_byt;
                mem_wr_data_q <= grant_m1 ? bus.m1_wr_data : bus.m0_wr_data;
                op_wr_q       <= grant_m1 ? bus.m1_wr      : bus.m0_wr;
                owner_q       <= grant_m1;
                last_grant_q  <= grant_m1;
            end else if (state_q == ACCESS) begin
                mem_wr_q <= 1'b0;       // write strobe lasts only for ACCESS
            end

            m0_ack_q <= (state_q == ACCESS) && !owner_q;
            m1_ack_q <= (state_q == ACCESS) &&  owner_q;

            // Keep the last read word so rd_data stays stable after the ack.
            if (state_q == DONE && !op_wr_q) begin
                if (owner_q) m1_hold_q <= bus.mem_rd_data;
                else         m0_hold_q <= bus.mem_rd_data;
            end
        end
    end

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.mem_byt     = mem_byt_q;
    assign bus.mem_wr_data = mem_wr_data_q;
    assign bus.m0_ack      = m0_ack_q;
    assign bus.m1_ack      = m1_ack_q;
    assign bus.busy        = (state_q != IDLE);

    // The BRAM output is itself a register that becomes valid in DONE, so it
    // is forwarded during a read ack; otherwise the held copy is shown.
    assign bus.m0_rd_data = (m0_ack_q && !op_wr_q) ? bus.mem_rd_data : m0_hold_q;
    assign bus.m1_rd_data = (m1_ack_q && !op_wr_q) ? bus.mem_rd_data : m1_hold_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a behavioural lo/hi byte BRAM model.
//   Stimulus pushes expected acks into a scoreboard queue; a negedge monitor
//   pops and compares whenever an ack appears. Cycle-level properties
//   (latency, mem_* contents, reset behaviour) are checked inline.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW)) bus ();

    mem_arbiter #(.AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        master;   // 0 = m0, 1 = m1
        logic        is_read;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // ---------------- BRAM model: one-cycle read latency -------------------
    logic [15:0] mem_arr [0:1023];

    always @(posedge clk) begin
        if (rst) begin
            mem_arr[10'h180] <= 16'h1234;   // byte address 0x0300
            mem_arr[10'h181] <= 16'hCAFE;   // byte address 0x0302
            bus.mem_rd_data  <= 16'h0000;
        end else begin
            if (bus.mem_wr) begin
                if (bus.mem_byt) begin
                    if (bus.mem_addr[0]) mem_arr[bus.mem_addr[10:1]][15:8] <= bus.mem_wr_data[7:0];
                    else                 mem_arr[bus.mem_addr[10:1]][7:0]  <= bus.mem_wr_data[7:0];
                end else begin
                    mem_arr[bus.mem_addr[10:1]] <= bus.mem_wr_data;
                end
            end
            bus.mem_rd_data <= mem_arr[bus.mem_addr[10:1]];
        end
    end

    // ---------------- helpers ---------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic req, input logic wr, input logic byt,
                           input logic [AW-1:0] addr, input logic [15:0] data);
        if (m == 0) begin
            bus.m0_req = req; bus.m0_wr = wr; bus.m0_byt = byt;
            bus.m0_addr = addr; bus.m0_wr_data = data;
        end else begin
            bus.m1_req = req; bus.m1_wr = wr; bus.m1_byt = byt;
            bus.m1_addr = addr; bus.m1_wr_data = data;
        end
    endtask

    task automatic push_exp(input logic m, input logic rd, input logic [15:0] d);
        exp_t e;
        e.master  = m;
        e.is_read = rd;
        e.data    = d;
        exp_q.push_back(e);
    endtask

    // One isolated access: req in cycle T, mem_* in T+1, ack in T+2, drop in T+3.
    task automatic single_access(input int m, input logic wr, input logic byt,
                                 input logic [AW-1:0] addr, input logic [15:0] data,
                                 input logic [15:0] exp_rd, input string tag);
        tick();
        set_req(m, 1'b1, wr, byt, addr, data);
        push_exp(m[0], !wr, exp_rd);
        tick();
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(addr));
        check({tag, "_mem_wr"},   32'(bus.mem_wr),   32'(wr));
        check({tag, "_mem_byt"},  32'(bus.mem_byt),  32'(byt));
        if (wr) check({tag, "_mem_wr_data"}, 32'(bus.mem_wr_data), 32'(data));
        check({tag, "_no_early_ack"}, 32'({bus.m1_ack, bus.m0_ack}), 32'(0));
        tick();
        check({tag, "_ack_t2"}, 32'(m == 0 ? bus.m0_ack : bus.m1_ack), 32'(1));
        check({tag, "_mem_wr_done"}, 32'(bus.mem_wr), 32'(0));
        check({tag, "_busy_done"}, 32'(bus.busy), 32'(1));
        tick();
        set_req(m, 1'b0, 1'b0, 1'b0, '0, '0);
        check({tag, "_idle_after"}, 32'(bus.busy), 32'(0));
    endtask

    // ---------------- scoreboard monitor ----------------------------------
    always @(negedge clk) begin
        if (!rst && (bus.m0_ack || bus.m1_ack)) begin
            check("single_ack", 32'(bus.m0_ack & bus.m1_ack), 32'(0));
            if (exp_q.size() == 0) begin
                check("spurious_ack", 32'({bus.m1_ack, bus.m0_ack}), 32'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_master", 32'(bus.m1_ack), 32'(mon_e.master));
                if (mon_e.is_read)
                    check("rd_data", 32'(mon_e.master ? bus.m1_rd_data : bus.m0_rd_data),
                          32'(mon_e.data));
            end
        end
    end

    // ---------------- stimulus --------------------------------------------
    initial begin
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) tick();

        // Reset state
        check("rst_mem_addr",    32'(bus.mem_addr),    32'(0));
        check("rst_mem_wr",      32'(bus.mem_wr),      32'(0));
        check("rst_mem_byt",     32'(bus.mem_byt),     32'(0));
        check("rst_mem_wr_data", 32'(bus.mem_wr_data), 32'(0));
        check("rst_acks",        32'({bus.m1_ack, bus.m0_ack}), 32'(0));
        check("rst_m0_rd_data",  32'(bus.m0_rd_data),  32'(0));
        check("rst_m1_rd_data",  32'(bus.m1_rd_data),  32'(0));
        check("rst_busy",        32'(bus.busy),        32'(0));
        rst = 1'b0;

        // Single read, write/read-back, byte write merged into a word read
        single_access(0, 1'b0, 1'b0, 16'h0300, 16'h0000, 16'h1234, "rd0300");
        single_access(1, 1'b1, 1'b0, 16'h0400, 16'hBEEF, 16'h0000, "wr0400");
        single_access(1, 1'b0, 1'b0, 16'h0400, 16'h0000, 16'hBEEF, "rd0400");
        single_access(0, 1'b1, 1'b1, 16'h0401, 16'h005A, 16'h0000, "bytewr");
        check("m0_rd_hold_after_write", 32'(bus.m0_rd_data), 32'(16'h1234));
        single_access(1, 1'b0, 1'b0, 16'h0400, 16'h0000, 16'h5AEF, "rd5aef");

        // Request hold-over: req stays high past the ack with a new address
        tick();
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0300, 16'h0000);
        push_exp(1'b0, 1'b1, 16'h1234);
        tick();
        tick();
        check("hold_first_ack", 32'(bus.m0_ack), 32'(1));
        tick();
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0302, 16'h0000);
        push_exp(1'b0, 1'b1, 16'hCAFE);
        check("hold_gap_ack", 32'(bus.m0_ack), 32'(0));
        check("hold_gap_idle", 32'(bus.busy), 32'(0));
        tick();
        check("hold_mem_addr", 32'(bus.mem_addr), 32'(16'h0302));
        check("hold_access_no_ack", 32'(bus.m0_ack), 32'(0));
        tick();
        check("hold_second_ack", 32'(bus.m0_ack), 32'(1));
        tick();
        set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);

        // Reset during ACCESS of an m0 read: no ack, everything back to zero
        tick();
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0302, 16'h0000);
        tick();
        check("midrst_in_access", 32'(bus.busy), 32'(1));
        rst = 1'b1;
        #1;
        check("midrst_mem_addr",   32'(bus.mem_addr),   32'(0));
        check("midrst_mem_wr",     32'(bus.mem_wr),     32'(0));
        check("midrst_acks",       32'({bus.m1_ack, bus.m0_ack}), 32'(0));
        check("midrst_m0_rd_data", 32'(bus.m0_rd_data), 32'(0));
        check("midrst_busy",       32'(bus.busy),       32'(0));
        set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        check("midrst_no_late_ack", 32'({bus.m1_ack, bus.m0_ack}), 32'(0));

        // Contention from reset: both held for 8 accesses, strict alternation
        tick();
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0300, 16'h0000);
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0400, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            push_exp(1'b0, 1'b1, 16'h1234);
            push_exp(1'b1, 1'b1, 16'h5AEF);
        end
        for (int c = 1; c <= 16; c++) begin
            tick();
            check($sformatf("cont_m0_ack_c%0d", c), 32'(bus.m0_ack),
                  32'((c % 4) == 2));
            check($sformatf("cont_m1_ack_c%0d", c), 32'(bus.m1_ack),
                  32'((c % 4) == 0));
            if (c == 15) set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
        end
        tick();
        set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
        check("cont_idle_after", 32'(bus.busy), 32'(0));
        tick();
        check("cont_stays_idle", 32'(bus.busy), 32'(0));

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
